// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory port arbiter.
package dmem_arb_pkg;

   localparam int unsigned STALL_CNT_W = 16;

   typedef enum logic {
      D_IDLE = 1'b0,
      D_ACK  = 1'b1
   } dbg_state_t;

   typedef enum logic [1:0] {
      G_NONE = 2'd0,
      G_CORE = 2'd1,
      G_DBG  = 2'd2
   } grant_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage and the debug/loader
// port. The core normally wins. Debug wins when the core is idle, when the
// core is halted, or once debug has lost MAX_WAIT consecutive cycles.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 9,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   halted,
   input  logic                   core_rd,
   input  logic                   core_wr,
   input  logic [ADDR_W-1:0]      core_addr,
   input  logic [DATA_W-1:0]      core_wr_data,
   output logic [DATA_W-1:0]      core_rd_data,
   output logic                   core_stall,
   input  logic                   dbg_req,
   input  logic                   dbg_we,
   input  logic [ADDR_W-1:0]      dbg_addr,
   input  logic [DATA_W-1:0]      dbg_wr_data,
   output logic                   dbg_ack,
   output logic [DATA_W-1:0]      dbg_rd_data,
   output logic                   mem_rd,
   output logic                   mem_wr,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wr_data,
   input  logic [DATA_W-1:0]      mem_rd_data,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   dbg_state_t              state_q, state_d;
   grant_t                  grant;
   logic [WAIT_W-1:0]       wait_cnt, wait_d;
   logic [STALL_CNT_W-1:0]  stall_d;
   logic                    ack_d;
   logic [DATA_W-1:0]       rd_data_d;
   logic                    core_req;
   logic                    dbg_pend;

   assign core_req = core_rd | core_wr;
   assign dbg_pend = dbg_req & (state_q == D_IDLE);

   // Grant decision, port muxing, FSM next state and counter updates
   always_comb begin
      grant        = G_NONE;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wr_data  = '0;
      core_rd_data = '0;
      core_stall   = 1'b0;
      state_d      = state_q;
      wait_d       = wait_cnt;
      stall_d      = stall_cycles;
      ack_d        = 1'b0;
      rd_data_d    = dbg_rd_data;

      if (dbg_pend && (halted || !core_req || wait_cnt == WAIT_W'(MAX_WAIT)))
         grant = G_DBG;
      else if (core_req)
         grant = G_CORE;

      case (grant)
         G_CORE: begin
            // a simultaneous read and write is treated as a write
            mem_wr       = core_wr;
            mem_rd       = core_rd & ~core_wr;
            mem_addr     = core_addr;
            mem_wr_data  = core_wr_data;
            core_rd_data = mem_rd_data;
         end
         G_DBG: begin
            mem_wr      = dbg_we;
            mem_rd      = ~dbg_we;
            mem_addr    = dbg_addr;
            mem_wr_data = dbg_wr_data;
         end
         default: ;
      endcase

      core_stall = core_req & (grant == G_DBG) & ~halted;

      // keep the memory and pipeline quiet while reset is held
      if (!reset) begin
         mem_rd     = 1'b0;
         mem_wr     = 1'b0;
         core_stall = 1'b0;
      end

      case (state_q)
         D_IDLE: begin
            if (grant == G_DBG) begin
               state_d = D_ACK;
               ack_d   = 1'b1;
               if (!dbg_we)
                  rd_data_d = mem_rd_data;
            end
         end
         D_ACK:   state_d = D_IDLE;
         default: state_d = D_IDLE;
      endcase

      if (!dbg_req || grant == G_DBG)
         wait_d = '0;
      else if (dbg_pend && grant == G_CORE && wait_cnt != WAIT_W'(MAX_WAIT))
         wait_d = wait_cnt + WAIT_W'(1);

      if (core_stall && stall_cycles != '1)
         stall_d = stall_cycles + STALL_CNT_W'(1);
   end

   // State, ack, debug read data and counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= D_IDLE;
         dbg_ack      <= 1'b0;
         dbg_rd_data  <= '0;
         wait_cnt     <= '0;
         stall_cycles <= '0;
      end else begin
         state_q      <= state_d;
         dbg_ack      <= ack_d;
         dbg_rd_data  <= rd_data_d;
         wait_cnt     <= wait_d;
         stall_cycles <= stall_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 512-word memory.
module tb_dmem_arbiter;

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              halted;
   logic              core_rd, core_wr;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wr_data;
   logic [DATA_W-1:0] core_rd_data;
   logic              core_stall;
   logic              dbg_req, dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wr_data;
   logic              dbg_ack;
   logic [DATA_W-1:0] dbg_rd_data;
   logic              mem_rd, mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic [DATA_W-1:0] mem_rd_data;
   logic [15:0]       stall_cycles;

   logic [DATA_W-1:0] mem [512];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Behavioural memory: combinational read, write on the clock edge
   assign mem_rd_data = mem[mem_addr];
   always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wr_data;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset), .halted(halted),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
      .core_wr_data(core_wr_data), .core_rd_data(core_rd_data),
      .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wr_data(dbg_wr_data), .dbg_ack(dbg_ack), .dbg_rd_data(dbg_rd_data),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
      .stall_cycles(stall_cycles)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // advance past the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic core_idle();
      core_rd = 1'b0; core_wr = 1'b0; core_addr = '0; core_wr_data = '0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = '0;
      halted = 1'b0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wr_data = '0;
      core_idle();

      // reset with a core write pending: strobes must stay low
      reset = 1'b0;
      core_wr = 1'b1; core_addr = 9'h010; core_wr_data = 32'h0BAD_0BAD;
      #12;
      check("rst_ack", 32'(dbg_ack), 32'd0);
      check("rst_rd_data", dbg_rd_data, 32'd0);
      check("rst_stall_cnt", 32'(stall_cycles), 32'd0);
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_core_stall", 32'(core_stall), 32'd0);
      core_idle();
      reset = 1'b1;
      tick();

      // core-only write then read
      core_wr = 1'b1; core_addr = 9'h010; core_wr_data = 32'hDEAD_BEEF;
      #1;
      check("core_wr_strobe", 32'(mem_wr), 32'd1);
      check("core_wr_stall", 32'(core_stall), 32'd0);
      tick();
      core_wr = 1'b0; core_rd = 1'b1;
      #1;
      check("core_rd_data", core_rd_data, 32'hDEAD_BEEF);
      check("core_rd_stall", 32'(core_stall), 32'd0);
      tick();
      // read and write together behave as a write
      core_rd = 1'b1; core_wr = 1'b1; core_addr = 9'h020; core_wr_data = 32'h0000_A5A5;
      #1;
      check("rdwr_mem_rd", 32'(mem_rd), 32'd0);
      check("rdwr_mem_wr", 32'(mem_wr), 32'd1);
      tick();
      core_idle();
      #1;
      check("core_only_stall_cnt", 32'(stall_cycles), 32'd0);

      // idle debug read
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h010;
      #1;
      check("idle_dbg_mem_rd", 32'(mem_rd), 32'd1);
      check("idle_dbg_addr", 32'(mem_addr), 32'h010);
      check("idle_dbg_stall", 32'(core_stall), 32'd0);
      check("idle_dbg_ack_c0", 32'(dbg_ack), 32'd0);
      tick();
      check("idle_dbg_ack_c1", 32'(dbg_ack), 32'd1);
      check("idle_dbg_rd_data", dbg_rd_data, 32'hDEAD_BEEF);
      dbg_req = 1'b0;
      #1;
      check("ack_cycle_no_grant", 32'(mem_rd), 32'd0);
      tick();
      check("idle_dbg_ack_fall", 32'(dbg_ack), 32'd0);

      // starvation: core busy every cycle, debug held
      core_rd = 1'b1; core_addr = 9'h020;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h010;
      for (int c = 0; c < 4; c++) begin
         #1;
         check($sformatf("starve_c%0d_stall", c), 32'(core_stall), 32'd0);
         check($sformatf("starve_c%0d_core_data", c), core_rd_data, 32'h0000_A5A5);
         check($sformatf("starve_c%0d_ack", c), 32'(dbg_ack), 32'd0);
         tick();
      end
      #1;
      check("starve_c4_stall", 32'(core_stall), 32'd1);
      check("starve_c4_addr", 32'(mem_addr), 32'h010);
      check("starve_c4_core_data", core_rd_data, 32'd0);
      tick();
      dbg_req = 1'b0;
      #1;
      check("starve_c5_ack", 32'(dbg_ack), 32'd1);
      check("starve_c5_rd_data", dbg_rd_data, 32'hDEAD_BEEF);
      check("starve_c5_stall", 32'(core_stall), 32'd0);
      check("starve_c5_core_data", core_rd_data, 32'h0000_A5A5);
      check("starve_stall_cnt", 32'(stall_cycles), 32'd1);
      tick();
      core_idle();

      // halted: debug write wins immediately without stalling
      halted = 1'b1;
      core_rd = 1'b1; core_addr = 9'h020;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h1FF; dbg_wr_data = 32'h1234_5678;
      #1;
      check("halt_mem_wr", 32'(mem_wr), 32'd1);
      check("halt_mem_rd", 32'(mem_rd), 32'd0);
      check("halt_addr", 32'(mem_addr), 32'h1FF);
      check("halt_stall", 32'(core_stall), 32'd0);
      tick();
      check("halt_ack", 32'(dbg_ack), 32'd1);
      dbg_req = 1'b0; halted = 1'b0; core_addr = 9'h1FF;
      #1;
      check("halt_readback", core_rd_data, 32'h1234_5678);
      tick();
      core_idle();

      // back-to-back debug reads: grants in even cycles, acks in odd cycles
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h1FF;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("b2b_c%0d_grant", k), 32'(mem_rd), (k % 2 == 0) ? 32'd1 : 32'd0);
         tick();
         check($sformatf("b2b_c%0d_ack", k + 1), 32'(dbg_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      check("b2b_rd_data", dbg_rd_data, 32'h1234_5678);
      dbg_req = 1'b0;
      tick();
      check("b2b_stall_cnt", 32'(stall_cycles), 32'd1);

      // reset during the ack cycle drops the ack
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h010;
      tick();
      check("rst_mid_ack_pre", 32'(dbg_ack), 32'd1);
      dbg_req = 1'b0;
      core_wr = 1'b1; core_addr = 9'h030; core_wr_data = 32'hFFFF_FFFF;
      reset = 1'b0;
      #1;
      check("rst_mid_ack", 32'(dbg_ack), 32'd0);
      check("rst_mid_stall_cnt", 32'(stall_cycles), 32'd0);
      check("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_mid_core_stall", 32'(core_stall), 32'd0);
      tick();
      check("rst_mid_mem_wr_held", 32'(mem_wr), 32'd0);
      core_idle();
      reset = 1'b1;
      tick();
      check("rst_mid_ack_after", 32'(dbg_ack), 32'd0);
      check("rst_mid_no_write", mem[9'h030], 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the pipeline MEM stage and a debug/loader port. Holds a 2-state debug-transaction FSM, a starvation counter and a stall-cycle counter. Sits between the Datapath MEM stage and the data memory. Stalls the core only when debug traffic must win.

## Interface
- `ADDR_W`, 9, memory word-address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 4, maximum number of consecutive cycles a pending debug request may lose to the core (≥1)
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `halted`  in  1  core HaltedState; debug always wins while high
- `core_rd`, `core_wr`  in  1 each  MEM-stage read/write strobes
- `core_addr`  in  ADDR_W  MEM-stage address
- `core_wr_data`  in  DATA_W  store data
- `core_rd_data`  out  DATA_W  load data, combinational; 0 when core not granted
- `core_stall`  out  1  combinational; freeze the pipeline this cycle
- `dbg_req`  in  1  debug request, held stable until `dbg_ack`
- `dbg_we`  in  1  1 = write, 0 = read
- `dbg_addr`  in  ADDR_W  debug address
- `dbg_wr_data`  in  DATA_W  debug write data
- `dbg_ack`  out  1  registered one-cycle completion pulse
- `dbg_rd_data`  out  DATA_W  registered read data, valid with `dbg_ack`, held until the next ack
- `mem_rd`, `mem_wr`  out  1 each  memory strobes
- `mem_addr`  out  ADDR_W  memory address
- `mem_wr_data`  out  DATA_W  memory write data
- `mem_rd_data`  in  DATA_W  memory read data, combinational, same cycle as address
- `stall_cycles`  out  16  saturating count of cycles with `core_stall`=1

## Operation
- `core_req` = `core_rd`|`core_wr`.
- If `core_rd` and `core_wr` are both high, treat the access as a write and ignore the read.
- `dbg_pend` = `dbg_req` & (state == D_IDLE).
- Grant decision, combinational each cycle:
  - DBG if `dbg_pend` & (`halted` | !`core_req` | `wait_cnt`==MAX_WAIT).
  - Else CORE if `core_req`.
  - Else NONE.
- CORE grant: the memory port is driven from the `core_*` signals, and `core_rd_data` = `mem_rd_data`.
- DBG grant: the memory port is driven from the `dbg_*` signals. `mem_rd`=!`dbg_we` and `mem_wr`=`dbg_we`.
- NONE: all memory strobes are 0. Address and data outputs are don't-care and driven 0.
- `core_stall` = `core_req` & (grant == DBG) & !`halted`.
- FSM (`dbg_state_t`):
  - D_IDLE → D_ACK on a DBG grant. Register `dbg_ack`=1, and if reading, register `dbg_rd_data` ← `mem_rd_data`.
  - D_ACK → D_IDLE unconditionally. `dbg_ack` falls.
  - No debug grant is made in D_ACK. If `dbg_req` is still high in D_IDLE, that is a new transaction. Maximum debug throughput is 1 access per 2 cycles.
- `wait_cnt` (clog2(MAX_WAIT+1) bits):
  - +1 on each cycle `dbg_pend` holds and the grant is CORE, saturating at MAX_WAIT.
  - Cleared on a DBG grant or when `dbg_req`=0.
- `stall_cycles`: +1 on each cycle `core_stall`=1, saturating at 0xFFFF. Cleared only by reset.

## Timing
- Reset (`reset`=0, asynchronous):
  - FSM = D_IDLE, `dbg_ack`=0, `dbg_rd_data`=0, `wait_cnt`=0, `stall_cycles`=0.
  - `mem_rd`/`mem_wr` forced to 0 and `core_stall`=0 while reset is low.
- Core path has zero latency: a load completes in the cycle it is granted.
- A core access is stalled at most 1 cycle per debug transaction, because the D_ACK cycle always goes to the core.
- Debug latency is 1 cycle from grant to `dbg_ack`. Worst case from `dbg_req` to `dbg_ack` with the core busy every cycle is MAX_WAIT+1 cycles.
- `halted` rising mid-wait: the debug request is granted the same cycle regardless of `wait_cnt`.
- `dbg_req` dropping before ack (protocol violation): no grant is made and `wait_cnt` clears. A transaction already granted still completes and pulses `dbg_ack`.
- Reset asserted in D_ACK: the ack is lost, and the debug master must reissue.

## Structure
- Package `dmem_arb_pkg`:
  - `dbg_state_t` {D_IDLE, D_ACK}
  - `grant_t` {G_NONE, G_CORE, G_DBG}
  - `STALL_CNT_W`=16
- Single module `dmem_arbiter`; no sub-module.
- All muxing is in one `always_comb` keyed on `grant_t`.
- Flops are in one `always_ff @(posedge clk or negedge reset)`.

## Test plan
- Core-only: `core_wr` to addr 0x010 with 0xDEADBEEF, then `core_rd` from 0x010. Required: `core_rd_data`=0xDEADBEEF, `core_stall` never 1, `stall_cycles`=0.
- Idle debug read: core idle, `dbg_req`=1, `dbg_we`=0, addr 0x010. Required: DBG grant in cycle 0, `dbg_ack`=1 with `dbg_rd_data`=0xDEADBEEF in cycle 1, `core_stall`=0.
- Starvation, MAX_WAIT=4: core requests every cycle and `dbg_req` is held. Required:
  - core granted cycles 0–3;
  - debug granted cycle 4 with `core_stall`=1;
  - `dbg_ack` in cycle 5;
  - `stall_cycles`=1.
- Halted: `halted`=1 and `core_rd`=1 concurrent with `dbg_req` write of 0x12345678 to 0x1FF. Required: DBG grant immediately, `core_stall`=0, later read of 0x1FF returns 0x12345678.
- Back-to-back debug: `dbg_req` held for 3 transactions. Required: acks in cycles 1, 3, 5, with no grant in any D_ACK cycle.
- Reset mid-transaction: `reset` low in the D_ACK cycle. Required: `dbg_ack`=0 and `stall_cycles`=0 immediately, `mem_wr`=0 while reset is low.
